// File: rtl/swervolf_sw_debounce_if.sv
// swervolf_sw_debounce_if
//   Switch-debouncer signal bundle between the board pads/CSR side and the
//   debouncer.
//   master : drives the raw pads (i_sw) and the event clear (i_evt_clr), and
//            observes the filtered state, strobes, events and irq.
//   slave  : the debouncer itself.
//   i_sw      [WIDTH] raw switch pads, asynchronous to clk
//   o_sw      [WIDTH] debounced switch state
//   o_rise    [WIDTH] one-cycle strobe on a debounced 0->1 change
//   o_fall    [WIDTH] one-cycle strobe on a debounced 1->0 change
//   i_evt_clr [WIDTH] write-1-to-clear for o_evt
//   o_evt     [WIDTH] sticky per-bit change flags
//   o_irq     [1]     OR of o_evt
interface swervolf_sw_debounce_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic [WIDTH-1:0] i_evt_clr;
  logic [WIDTH-1:0] o_evt;
  logic             o_irq;

  modport master (
    output i_sw, i_evt_clr,
    input  o_sw, o_rise, o_fall, o_evt, o_irq
  );

  modport slave (
    input  i_sw, i_evt_clr,
    output o_sw, o_rise, o_fall, o_evt, o_irq
  );
endinterface

// File: rtl/swervolf_sw_debounce.sv
// swervolf_sw_debounce
//   Per-bit debouncer and edge detector for the board slide switches feeding
//   the SweRVolf GPIO input. Raw pads pass through a two-flop synchroniser,
//   then each bit is filtered: the debounced value only follows the
//   synchronised input after it has differed for STABLE_TICKS consecutive
//   ticks of a shared free-running prescaler.
//   Ports:
//     clk  core clock
//     rst  asynchronous active-high reset
//     bus  swervolf_sw_debounce_if.slave (i_sw, o_sw, o_rise, o_fall,
//          i_evt_clr, o_evt, o_irq)
//   Parameters: WIDTH, PRESCALE (>=1), STABLE_TICKS (>=1).
//   Optional feature macro SW_DEBOUNCE_EVT_EN: when defined, sticky per-bit
//   event flags (set by rise/fall, write-1-to-clear, set wins) and o_irq are
//   built; otherwise o_evt/o_irq are tied to 0 and i_evt_clr is ignored.
module swervolf_sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int PRESCALE     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  swervolf_sw_debounce_if.slave  bus
);

  // PRESCALE=1 would give a zero-width counter; keep one bit, it never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1_q;
  logic [WIDTH-1:0]         sync2_q;
  logic [PW-1:0]            pre_q, pre_d;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         sw_q, sw_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // A bit that matches the filtered value clears its counter every cycle, so
  // any bounce back restarts filtering from scratch.
  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]  = '0;
          sw_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= bus.i_sw;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.o_sw   = sw_q;
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;

`ifdef SW_DEBOUNCE_EVT_EN
  logic [WIDTH-1:0] evt_q, evt_d;

  // Set is ORed in after the clear so a strobe in the clear cycle survives.
  always_comb begin
    evt_d = (evt_q & ~bus.i_evt_clr) | rise_q | fall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.o_evt = evt_q;
  assign bus.o_irq = |evt_q;
`else
  logic unused_evt_clr;

  assign unused_evt_clr = ^bus.i_evt_clr;
  assign bus.o_evt      = '0;
  assign bus.o_irq      = 1'b0;
`endif

endmodule
